// File: rtl/rob.sv
// Circular reorder buffer: up to `N in-order dispatches at the tail and up to `N retires at the head per cycle.
// Optional ROB_PERF_CNT_EN adds perf_retired_cnt / perf_full_cycles counters.

`ifndef N
`define N 3
`endif
`ifndef ROB_SZ
`define ROB_SZ 32
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS $clog2(`N+1)
`endif

`ifndef ROB_PACKET_T
`define ROB_PACKET_T
typedef struct packed {
   logic [31:0] pc;
   logic [4:0]  arch_reg;
   logic [5:0]  t_new;
   logic [5:0]  t_old;
   logic        complete;
} ROB_PACKET;
`endif

module rob #(
   parameter int DEPTH = `ROB_SZ,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  ROB_PACKET [`N-1:0]           rob_inputs,
   input  logic [`NUM_SCALAR_BITS-1:0]  rob_inputs_valid,
   output logic [`NUM_SCALAR_BITS-1:0]  rob_spots,
   output logic [IDX_W-1:0]             rob_tail,
   output ROB_PACKET [`N-1:0]           rob_outputs,
   output logic [`NUM_SCALAR_BITS-1:0]  rob_outputs_valid,
   input  logic [`NUM_SCALAR_BITS-1:0]  num_retiring,
   input  logic                         rob_squash,
   input  logic [IDX_W-1:0]             squash_idx
`ifdef ROB_PERF_CNT_EN
   ,
   output logic [63:0]                  perf_retired_cnt,
   output logic [31:0]                  perf_full_cycles
`endif
);

   localparam int NW    = `N;
   localparam int SB    = `NUM_SCALAR_BITS;
   localparam int CNT_W = $clog2(DEPTH + 1);

   ROB_PACKET        entries_q [DEPTH];
   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] free_w;
   logic [CNT_W-1:0] span_w;

   logic [IDX_W-1:0] wr_idx [NW];
   logic             wr_en  [NW];
   logic [IDX_W-1:0] rd_idx [NW];

   // Per-slot write/read addresses wrap by natural IDX_W truncation.
   generate
      for (genvar gi = 0; gi < NW; gi++) begin : g_slot
         assign wr_idx[gi]      = tail_q + IDX_W'(gi);
         assign wr_en[gi]       = !rob_squash && (SB'(gi) < rob_inputs_valid);
         assign rd_idx[gi]      = head_q + IDX_W'(gi);
         assign rob_outputs[gi] = entries_q[rd_idx[gi]];
      end
   endgenerate

   assign free_w            = CNT_W'(DEPTH) - count_q;
   assign rob_spots         = (free_w > CNT_W'(NW)) ? SB'(NW) : free_w[SB-1:0];
   assign rob_outputs_valid = (count_q > CNT_W'(NW)) ? SB'(NW) : count_q[SB-1:0];
   assign rob_tail          = tail_q;

   // Live entries up to and including the branch: 1..DEPTH, since the branch is retained.
   assign span_w = CNT_W'({1'b0, squash_idx - head_q}) + CNT_W'(1);

   always_comb begin
      head_d  = head_q + IDX_W'(num_retiring);
      tail_d  = tail_q + IDX_W'(rob_inputs_valid);
      count_d = count_q + CNT_W'(rob_inputs_valid) - CNT_W'(num_retiring);
      if (rob_squash) begin
         tail_d  = squash_idx + IDX_W'(1);
         count_d = span_w - CNT_W'(num_retiring);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < NW; i++) begin
            if (wr_en[i]) begin
               entries_q[wr_idx[i]] <= rob_inputs[i];
            end
         end
      end
   end

`ifdef ROB_PERF_CNT_EN
   logic [63:0] perf_retired_q;
   logic [31:0] perf_full_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_retired_q <= '0;
         perf_full_q    <= '0;
      end else begin
         perf_retired_q <= perf_retired_q + 64'(num_retiring);
         if (count_q == CNT_W'(DEPTH)) begin
            perf_full_q <= perf_full_q + 32'd1;
         end
      end
   end

   assign perf_retired_cnt = perf_retired_q;
   assign perf_full_cycles = perf_full_q;
`endif

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob (N=3, DEPTH=8): driver queues expected state per step, monitor compares.

`ifndef N
`define N 3
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS $clog2(`N+1)
`endif

`ifndef ROB_PACKET_T
`define ROB_PACKET_T
typedef struct packed {
   logic [31:0] pc;
   logic [4:0]  arch_reg;
   logic [5:0]  t_new;
   logic [5:0]  t_old;
   logic        complete;
} ROB_PACKET;
`endif

module tb_rob;
   localparam int DEPTH = 8;
   localparam int IDX_W = 3;
   localparam int NW    = `N;
   localparam int SB    = `NUM_SCALAR_BITS;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   ROB_PACKET [NW-1:0] rob_inputs;
   logic [SB-1:0]    rob_inputs_valid;
   logic [SB-1:0]    rob_spots;
   logic [IDX_W-1:0] rob_tail;
   ROB_PACKET [NW-1:0] rob_outputs;
   logic [SB-1:0]    rob_outputs_valid;
   logic [SB-1:0]    num_retiring;
   logic             rob_squash;
   logic [IDX_W-1:0] squash_idx;
`ifdef ROB_PERF_CNT_EN
   logic [63:0]      perf_retired_cnt;
   logic [31:0]      perf_full_cycles;
`endif

   always #5 clock = ~clock;

   rob #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clock             (clock),
      .reset             (reset),
      .rob_inputs        (rob_inputs),
      .rob_inputs_valid  (rob_inputs_valid),
      .rob_spots         (rob_spots),
      .rob_tail          (rob_tail),
      .rob_outputs       (rob_outputs),
      .rob_outputs_valid (rob_outputs_valid),
      .num_retiring      (num_retiring),
      .rob_squash        (rob_squash),
      .squash_idx        (squash_idx)
`ifdef ROB_PERF_CNT_EN
      ,
      .perf_retired_cnt  (perf_retired_cnt),
      .perf_full_cycles  (perf_full_cycles)
`endif
   );

   typedef struct {
      string tag;
      int    spots;
      int    ov;
      int    tail;
      int    t0;
      int    t1;
      int    t2;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   event mid_ev;

   // Packet k is fully determined by k; k == 0 denotes an all-zero entry.
   function automatic ROB_PACKET mk(input int k);
      ROB_PACKET p;
      p = '0;
      if (k != 0) begin
         p.pc       = 32'h1000 + 32'(k * 4);
         p.arch_reg = 5'(k + 3);
         p.t_new    = 6'(k);
         p.t_old    = 6'(k + 32);
         p.complete = 1'(k & 1);
      end
      return p;
   endfunction

   task automatic chk_int(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic chk_pkt(input string name, input ROB_PACKET act, input ROB_PACKET req);
      n_vec++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %h (t_new %0d), required %h (t_new %0d)",
                  name, act, act.t_new, req, req.t_new);
      end
   endtask

   task automatic push_exp(input string tag, input int sp, ov, tl, t0, t1, t2);
      exp_t e;
      e.tag = tag; e.spots = sp; e.ov = ov; e.tail = tl;
      e.t0 = t0; e.t1 = t1; e.t2 = t2;
      exp_q.push_back(e);
   endtask

   // One clock of stimulus; expected values describe the state after this edge.
   task automatic cyc(input string tag, input int nv, k0, nret, input bit sq, input int sidx,
                      input int sp, ov, tl, t0, t1, t2);
      for (int i = 0; i < NW; i++) begin
         rob_inputs[i] = (i < nv) ? mk(k0 + i) : mk(50 + i);
      end
      rob_inputs_valid = SB'(nv);
      num_retiring     = SB'(nret);
      rob_squash       = sq;
      squash_idx       = IDX_W'(sidx);
      @(posedge clock);
      push_exp(tag, sp, ov, tl, t0, t1, t2);
      #1;
      rob_inputs       = '0;
      rob_inputs_valid = '0;
      num_retiring     = '0;
      rob_squash       = 1'b0;
      squash_idx       = '0;
   endtask

   always @(negedge clock or mid_ev) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk_int({e.tag, " rob_spots"}, int'(rob_spots), e.spots);
         chk_int({e.tag, " rob_outputs_valid"}, int'(rob_outputs_valid), e.ov);
         chk_int({e.tag, " rob_tail"}, int'(rob_tail), e.tail);
         if (e.t0 >= 0) chk_pkt({e.tag, " out0"}, rob_outputs[0], mk(e.t0));
         if (e.t1 >= 0) chk_pkt({e.tag, " out1"}, rob_outputs[1], mk(e.t1));
         if (e.t2 >= 0) chk_pkt({e.tag, " out2"}, rob_outputs[2], mk(e.t2));
         $display("vector %-12s spots=%0d valid=%0d tail=%0d t_new=%0d,%0d,%0d",
                  e.tag, rob_spots, rob_outputs_valid, rob_tail,
                  rob_outputs[0].t_new, rob_outputs[1].t_new, rob_outputs[2].t_new);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rob_inputs       = '0;
      rob_inputs_valid = '0;
      num_retiring     = '0;
      rob_squash       = 1'b0;
      squash_idx       = '0;

      // Reset held low for two edges, then released.
      push_exp("reset_low", 3, 0, 0, 0, 0, 0);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      push_exp("reset_rel", 3, 0, 0, 0, 0, 0);

      //   tag          nv  k0 ret sq sidx  spots ov tail  t0 t1 t2
      cyc("fill1",      3,  1, 0, 0, 0,   3, 3, 3,   1, 2, 3);
      cyc("fill2",      3,  4, 0, 0, 0,   2, 3, 6,   1, 2, 3);
      cyc("fill3",      2,  7, 0, 0, 0,   0, 3, 0,   1, 2, 3);
      cyc("ret3",       0,  0, 3, 0, 0,   3, 3, 0,   4, 5, 6);
      cyc("wrap",       3,  9, 2, 0, 0,   2, 3, 3,   6, 7, 8);
      cyc("full2",      2, 12, 0, 0, 0,   0, 3, 5,   6, 7, 8);
      cyc("retfull",    0,  0, 3, 0, 0,   3, 3, 5,   9, 10, 11);
      cyc("drain1",     0,  0, 3, 0, 0,   3, 2, 5,  12, 13, 6);
      cyc("drain2",     0,  0, 2, 0, 0,   3, 0, 5,   6, 7, 8);
      cyc("refill1",    3, 14, 0, 0, 0,   3, 3, 0,  14, 15, 16);
      cyc("refill2",    2, 17, 0, 0, 0,   3, 3, 2,  14, 15, 16);

      // Asynchronous reset between edges with five live entries.
      @(negedge clock);
      #1;
`ifdef ROB_PERF_CNT_EN
      chk_int("perf_retired_cnt pre-reset", int'(perf_retired_cnt), 13);
      chk_int("perf_full_cycles pre-reset", int'(perf_full_cycles), 2);
`endif
      reset = 1'b0;
      push_exp("async_rst", 3, 0, 0, 0, 0, 0);
      #1;
      -> mid_ev;
`ifdef ROB_PERF_CNT_EN
      chk_int("perf_retired_cnt in reset", int'(perf_retired_cnt), 0);
      chk_int("perf_full_cycles in reset", int'(perf_full_cycles), 0);
`endif
      @(posedge clock);
      #1 reset = 1'b1;

      cyc("sq_a",       3, 21, 0, 0, 0,   3, 3, 3,  21, 22, 23);
      cyc("sq_b",       3, 24, 0, 0, 0,   2, 3, 6,  21, 22, 23);
      cyc("squash",     3, 27, 1, 1, 2,   3, 2, 3,  22, 23, 24);
      cyc("after_sq",   1, 30, 0, 0, 0,   3, 3, 4,  22, 23, 30);
      cyc("retall",     0,  0, 3, 0, 0,   3, 0, 4,  25, 26, 0);
      cyc("disp31",     3, 31, 0, 0, 0,   3, 3, 7,  31, 32, 33);
      cyc("sq_drain",   2, 40, 1, 1, 4,   3, 0, 5,  32, 33, 0);
      cyc("disp34",     3, 34, 0, 0, 0,   3, 3, 0,  34, 35, 36);
      cyc("sq_tail",    0,  0, 0, 1, 7,   3, 3, 0,  34, 35, 36);
      cyc("sq_head",    3, 45, 0, 1, 5,   3, 1, 6,  34, 35, 36);
      cyc("wrap_wr",    3, 37, 0, 0, 0,   3, 3, 1,  34, 37, 38);
      cyc("disp_ret",   3, 41, 2, 0, 0,   3, 3, 4,  38, 39, 41);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(negedge clock);
         #1;
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: got %0d pending, required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
